// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential double-dabble binary-to-BCD converter:
// FSM encoding, a clog2 helper and the digit-count sufficiency check.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // True when DIGITS decimal digits can hold the largest BIN_W-bit value.
  function automatic bit digits_ok(input int bin_w, input int digits);
    longint p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return p > ((longint'(1) << bin_w) - 1);
  endfunction

endpackage

// File: rtl/dd_add3.sv
// One double-dabble digit correction: add 3 when the BCD digit is 5 or more.
module dd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Input digit is at most 9, so the 4-bit sum never exceeds 12.
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock,
// with a start/busy/done handshake.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [1:0]            dbg_state
);

  localparam int CW = clog2(BIN_W + 1);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + BIN_W;

  if (BIN_W < 2) begin : g_bad_width
    $error("bin_to_bcd_seq: BIN_W must be at least 2");
  end
  if (!digits_ok(BIN_W, DIGITS)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
  end

  // Handshake: start is only looked at in IDLE; busy spans the SHIFT cycles;
  // done is a one-cycle pulse in DONE, and bcd_out holds until the next done.
  state_t          state;
  logic [SW-1:0]   shift_reg;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bcd_adj;
  logic [SW-1:0]   corr;
  logic [SW-1:0]   shift_nxt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    dd_add3 u_add3 (
      .din  (shift_reg[BIN_W + 4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  assign corr      = {bcd_adj, shift_reg[BIN_W-1:0]};
  assign shift_nxt = corr << 1;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shift_reg <= {{BW{1'b0}}, bin_in};
            cnt       <= CW'(BIN_W);
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= shift_nxt;
          cnt       <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd_out <= shift_nxt[SW-1 -: BW];
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
